// File: rtl/optrom_scanner.sv
// Option-ROM probe: checks the 55h/AAh signature and length byte, then re-reads the whole
// image over the registered-response read bus and streams it out while summing it mod 256.
module optrom_scanner #(
   parameter int MAX_BLOCKS = 64
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iStart,
   input  logic [19:0] iBase,
   output logic [19:0] oAddr,
   output logic        oRd,
   input  logic        iSel,
   input  logic [7:0]  iData,
   output logic [7:0]  oByte,
   output logic        oByteValid,
   input  logic        iByteReady,
   output logic        oBusy,
   output logic        oDone,
   output logic        oFound,
   output logic        oError,
   output logic        oSumOk,
   output logic [7:0]  oSizeBlocks
);

   localparam logic [7:0] MAX_LEN = 8'(MAX_BLOCKS);

   typedef enum logic [2:0] {IDLE, SIG0, SIG1, LEN, STREAM, HOLD, FINISH} stateT;

   stateT       state, stateNext;
   logic        sampling, samplingNext;
   logic [19:0] base, baseNext;
   logic [16:0] count, countNext;
   logic [7:0]  sum, sumNext;
   logic [19:0] addrNext;
   logic        rdNext, validNext, busyNext, doneNext, foundNext, errorNext, sumOkNext;
   logic [7:0]  byteNext, sizeNext;
   logic        finishNow;
   logic [16:0] countInc;

   assign countInc = count + 17'd1;

   // Each header/stream read spends one cycle issuing oRd and one cycle sampling the
   // registered response; every output is computed here and registered below.
   always_comb begin
      stateNext    = state;
      samplingNext = sampling;
      baseNext     = base;
      countNext    = count;
      sumNext      = sum;
      addrNext     = oAddr;
      rdNext       = 1'b0;
      byteNext     = oByte;
      validNext    = oByteValid;
      busyNext     = oBusy;
      doneNext     = 1'b0;
      foundNext    = oFound;
      errorNext    = oError;
      sumOkNext    = oSumOk;
      sizeNext     = oSizeBlocks;
      finishNow    = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) begin
               baseNext     = iBase;
               addrNext     = iBase;
               rdNext       = 1'b1;
               samplingNext = 1'b0;
               busyNext     = 1'b1;
               foundNext    = 1'b0;
               errorNext    = 1'b0;
               sumOkNext    = 1'b0;
               sizeNext     = 8'd0;
               stateNext    = SIG0;
            end
         end
         SIG0, SIG1, LEN: begin
            if (!sampling) begin
               samplingNext = 1'b1;
            end else begin
               samplingNext = 1'b0;
               if (!iSel) begin
                  finishNow = 1'b1;
               end else if (state == SIG0) begin
                  if (iData == 8'h55) begin
                     stateNext = SIG1;
                     addrNext  = base + 20'd1;
                     rdNext    = 1'b1;
                  end else begin
                     finishNow = 1'b1;
                  end
               end else if (state == SIG1) begin
                  if (iData == 8'hAA) begin
                     stateNext = LEN;
                     addrNext  = base + 20'd2;
                     rdNext    = 1'b1;
                  end else begin
                     finishNow = 1'b1;
                  end
               end else begin
                  sizeNext = iData;
                  if (iData == 8'd0 || iData > MAX_LEN) begin
                     errorNext = 1'b1;
                     finishNow = 1'b1;
                  end else begin
                     // Header passed: restart from offset 0 so the header is streamed and summed too.
                     foundNext = 1'b1;
                     countNext = 17'd0;
                     sumNext   = 8'd0;
                     addrNext  = base;
                     rdNext    = 1'b1;
                     stateNext = STREAM;
                  end
               end
            end
         end
         STREAM: begin
            if (!sampling) begin
               samplingNext = 1'b1;
            end else begin
               samplingNext = 1'b0;
               if (!iSel) begin
                  errorNext = 1'b1;
                  sumOkNext = 1'b0;
                  finishNow = 1'b1;
               end else begin
                  byteNext  = iData;
                  validNext = 1'b1;
                  sumNext   = sum + iData;
                  stateNext = HOLD;
               end
            end
         end
         HOLD: begin
            if (iByteReady) begin
               validNext = 1'b0;
               countNext = countInc;
               if (countInc == {oSizeBlocks, 9'd0}) begin
                  sumOkNext = (sum == 8'd0);
                  finishNow = 1'b1;
               end else begin
                  addrNext  = base + {3'd0, countInc};
                  rdNext    = 1'b1;
                  stateNext = STREAM;
               end
            end
         end
         FINISH: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      if (finishNow) begin
         stateNext = FINISH;
         busyNext  = 1'b0;
         doneNext  = 1'b1;
      end
   end

   // Synchronous active-low reset aborts any operation without a done pulse.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         state       <= IDLE;
         sampling    <= 1'b0;
         base        <= 20'd0;
         count       <= 17'd0;
         sum         <= 8'd0;
         oAddr       <= 20'd0;
         oRd         <= 1'b0;
         oByte       <= 8'd0;
         oByteValid  <= 1'b0;
         oBusy       <= 1'b0;
         oDone       <= 1'b0;
         oFound      <= 1'b0;
         oError      <= 1'b0;
         oSumOk      <= 1'b0;
         oSizeBlocks <= 8'd0;
      end else begin
         state       <= stateNext;
         sampling    <= samplingNext;
         base        <= baseNext;
         count       <= countNext;
         sum         <= sumNext;
         oAddr       <= addrNext;
         oRd         <= rdNext;
         oByte       <= byteNext;
         oByteValid  <= validNext;
         oBusy       <= busyNext;
         oDone       <= doneNext;
         oFound      <= foundNext;
         oError      <= errorNext;
         oSumOk      <= sumOkNext;
         oSizeBlocks <= sizeNext;
      end
   end

endmodule

// File: tb/tb_optrom_scanner.sv
// Bench for optrom_scanner: a registered ROM responder, a queue-based model of the expected
// read addresses, streamed bytes and final status, and a per-cycle compare process.
module tb_optrom_scanner;

   logic        iClk = 1'b0;
   logic        iRstN, iStart, iSel, iByteReady;
   logic [19:0] iBase, oAddr;
   logic [7:0]  iData, oByte, oSizeBlocks;
   logic        oRd, oByteValid, oBusy, oDone, oFound, oError, oSumOk;

   optrom_scanner #(.MAX_BLOCKS(64)) dut (
      .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iBase(iBase),
      .oAddr(oAddr), .oRd(oRd), .iSel(iSel), .iData(iData),
      .oByte(oByte), .oByteValid(oByteValid), .iByteReady(iByteReady),
      .oBusy(oBusy), .oDone(oDone), .oFound(oFound), .oError(oError),
      .oSumOk(oSumOk), .oSizeBlocks(oSizeBlocks)
   );

   always #5 iClk = ~iClk;

   int testCount = 0;
   int failCount = 0;

   logic [7:0]  image [0:32767];
   logic [19:0] respBase = 20'd0;
   bit          selEnable = 1'b1;
   int          dropOffset = -1;

   logic [19:0] expAddr[$];
   logic [7:0]  expBytes[$];
   logic        expFound, expError, expSumOk;
   logic [7:0]  expSize;

   bit          modelActive = 1'b0;
   bit          readyHigh = 1'b1;
   bit          prevRd = 1'b0;
   bit          haveLast;
   int          cycle = 0;
   int          rdCount, accepted, stallCycles, firstRdCycle, doneCycle, lastAcceptCycle;
   int          doneCount = 0;
   int          opDoneBase;
   logic [19:0] lastRdAddr;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit selected(input int off);
      return selEnable && off != dropOffset;
   endfunction

   // Expected behaviour derived from the image contents alone.
   task automatic buildModel(input logic [19:0] b);
      int sum;
      int n;
      expAddr.delete();
      expBytes.delete();
      expFound = 1'b0; expError = 1'b0; expSumOk = 1'b0; expSize = 8'd0;
      expAddr.push_back(b);
      if (!selected(0) || image[0] != 8'h55) return;
      expAddr.push_back(b + 20'd1);
      if (!selected(1) || image[1] != 8'hAA) return;
      expAddr.push_back(b + 20'd2);
      if (!selected(2)) return;
      expSize = image[2];
      if (expSize == 0 || expSize > 64) begin
         expError = 1'b1;
         return;
      end
      expFound = 1'b1;
      n = int'(expSize) * 512;
      sum = 0;
      for (int i = 0; i < n; i++) begin
         expAddr.push_back(b + 20'(i));
         if (!selected(i)) begin
            expError = 1'b1;
            return;
         end
         expBytes.push_back(image[i]);
         sum += int'(image[i]);
      end
      expSumOk = (sum % 256) == 0;
   endtask

   task automatic makeImage(input int blocks, input int seed);
      int n;
      int sum;
      n = blocks * 512;
      for (int i = 0; i < n; i++) image[i] = 8'((i * 7 + seed) ^ (i >> 3));
      image[0] = 8'h55;
      image[1] = 8'hAA;
      image[2] = 8'(blocks);
      sum = 0;
      for (int i = 0; i < n - 1; i++) sum += int'(image[i]);
      image[n-1] = 8'(256 - (sum % 256));
   endtask

   // Registered responder: select and data appear the cycle after the read strobe.
   logic       respSelD;
   logic [7:0] respDataD;
   always @(negedge iClk) begin
      logic [19:0] diff;
      int          off;
      diff = oAddr - respBase;
      off = int'(diff);
      respSelD  = oRd && selEnable && off < 32768 && off != dropOffset;
      respDataD = (off < 32768) ? image[off] : 8'h00;
   end
   always @(posedge iClk) begin
      #1;
      iSel  = respSelD;
      iData = respDataD;
   end

   always @(negedge iClk) begin
      cycle++;
      if (iRstN && oDone) begin
         doneCount++;
         doneCycle = cycle;
      end
      if (iRstN && modelActive) begin
         if (oRd) begin
            checkOutput("rdGap", prevRd, 0);
            checkOutput("busyOnRead", oBusy, 1);
            if (rdCount == 0) firstRdCycle = cycle;
            rdCount++;
            lastRdAddr = oAddr;
            if (expAddr.size() == 0) checkOutput("extraRead", 1, 0);
            else checkOutput("readAddr", oAddr, expAddr.pop_front());
         end
         if (oByteValid) begin
            checkOutput("rdWhileValid", oRd, 0);
            if (expBytes.size() == 0) checkOutput("extraByte", 1, 0);
            else checkOutput("streamByte", oByte, expBytes[0]);
            if (iByteReady) begin
               if (expBytes.size() != 0) void'(expBytes.pop_front());
               if (readyHigh && haveLast) checkOutput("throughput", cycle - lastAcceptCycle, 3);
               haveLast = 1'b1;
               lastAcceptCycle = cycle;
               accepted++;
            end else begin
               stallCycles++;
            end
         end
         if (oDone) begin
            checkOutput("busyAtDone", oBusy, 0);
            checkOutput("found", oFound, expFound);
            checkOutput("error", oError, expError);
            checkOutput("sumOk", oSumOk, expSumOk);
            checkOutput("sizeBlocks", oSizeBlocks, expSize);
            checkOutput("readsLeft", expAddr.size(), 0);
            checkOutput("bytesLeft", expBytes.size(), 0);
         end
      end
      prevRd = oRd;
   end

   task automatic resetDut();
      iRstN = 1'b0;
      modelActive = 1'b0;
      repeat (2) @(posedge iClk);
      #1 iRstN = 1'b1;
   endtask

   task automatic applyStimulus(input logic [19:0] b, input int extraHold);
      respBase = b;
      buildModel(b);
      rdCount = 0; accepted = 0; stallCycles = 0; haveLast = 1'b0;
      opDoneBase = doneCount;
      modelActive = 1'b1;
      iBase = b;
      iStart = 1'b1;
      repeat (1 + extraHold) @(posedge iClk);
      #1 iStart = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int i = 0;
      while (doneCount == opDoneBase && i < budget) begin
         @(posedge iClk);
         i++;
      end
      if (doneCount == opDoneBase) begin
         checkOutput("doneTimeout", 0, 1);
         resetDut();
      end
      repeat (3) @(posedge iClk);
      #1;
      checkOutput("doneOnce", doneCount - opDoneBase, 1);
      checkOutput("idleAfterDone", oBusy, 0);
   endtask

   task automatic waitAccepted(input int target);
      int i = 0;
      while (accepted < target && i < 3000) begin
         @(posedge iClk);
         i++;
      end
      checkOutput("reachedByte", accepted, target);
   endtask

   initial begin
      int rstDoneBase;
      iRstN = 1'b0; iStart = 1'b0; iBase = 20'd0; iByteReady = 1'b1;
      iSel = 1'b0; iData = 8'd0;
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      checkOutput("resetOutputs", {oAddr, oRd, oByte, oByteValid, oBusy, oDone,
                                   oFound, oError, oSumOk, oSizeBlocks}, 0);
      @(posedge iClk);
      #1 iRstN = 1'b1;
      @(posedge iClk);
      #1;

      // No device; iStart kept high through busy and the done cycle must be ignored.
      selEnable = 1'b0;
      makeImage(1, 3);
      applyStimulus(20'hC8000, 3);
      waitDone(50);
      checkOutput("noDevReads", rdCount, 1);
      checkOutput("noDevAddr", lastRdAddr, 20'hC8000);
      checkOutput("noDevDoneDelay", doneCycle - firstRdCycle, 2);
      checkOutput("noDevBytes", accepted, 0);
      checkOutput("noDevStatus", {oFound, oError}, 2'b00);
      selEnable = 1'b1;

      // Valid 1-block image.
      applyStimulus(20'hC8000, 0);
      waitDone(3000);
      checkOutput("validBytes", accepted, 512);
      checkOutput("validLastAddr", lastRdAddr, 20'hC81FF);
      checkOutput("validStatus", {oFound, oError, oSumOk, oSizeBlocks}, {3'b101, 8'h01});

      // Bad checksum: every byte still streamed.
      image[511] = image[511] + 8'd1;
      applyStimulus(20'hC8000, 0);
      waitDone(3000);
      checkOutput("badSumBytes", accepted, 512);
      checkOutput("badSumStatus", {oFound, oError, oSumOk}, 3'b100);
      image[511] = image[511] - 8'd1;

      // Length out of range at both ends.
      image[2] = 8'h00;
      applyStimulus(20'hC8000, 0);
      waitDone(50);
      checkOutput("len0Status", {oFound, oError, oSizeBlocks}, {2'b01, 8'h00});
      checkOutput("len0Bytes", accepted, 0);
      image[2] = 8'h41;
      applyStimulus(20'hC8000, 0);
      waitDone(50);
      checkOutput("len41Status", {oFound, oError, oSizeBlocks}, {2'b01, 8'h41});
      checkOutput("len41Bytes", accepted, 0);
      image[2] = 8'h01;

      // Backpressure at byte 3 for 10 cycles of held valid.
      readyHigh = 1'b0;
      applyStimulus(20'hC8000, 0);
      waitAccepted(3);
      #1 iByteReady = 1'b0;
      repeat (12) @(posedge iClk);
      #1 iByteReady = 1'b1;
      waitDone(3000);
      checkOutput("bpStalls", stallCycles, 10);
      checkOutput("bpBytes", accepted, 512);
      checkOutput("bpSumOk", oSumOk, 1);
      readyHigh = 1'b1;

      // Select lost at byte 200.
      dropOffset = 200;
      applyStimulus(20'hC8000, 0);
      waitDone(3000);
      checkOutput("lostBytes", accepted, 200);
      checkOutput("lostStatus", {oFound, oError, oSumOk}, 3'b110);
      dropOffset = -1;

      // Reset at byte 100, then a clean restart.
      applyStimulus(20'hC8000, 0);
      waitAccepted(100);
      #1 iRstN = 1'b0;
      modelActive = 1'b0;
      rstDoneBase = doneCount;
      @(posedge iClk);
      @(negedge iClk);
      checkOutput("midResetOutputs", {oAddr, oRd, oByte, oByteValid, oBusy, oDone,
                                      oFound, oError, oSumOk, oSizeBlocks}, 0);
      @(posedge iClk);
      #1 iRstN = 1'b1;
      repeat (3) @(posedge iClk);
      #1;
      checkOutput("noDoneAfterReset", doneCount - rstDoneBase, 0);
      applyStimulus(20'hC8000, 0);
      waitDone(3000);
      checkOutput("restartBytes", accepted, 512);
      checkOutput("restartSumOk", oSumOk, 1);

      // Two blocks across the top of the address space: silent wrap.
      makeImage(2, 11);
      applyStimulus(20'hFFE00, 0);
      waitDone(6000);
      checkOutput("wrapBytes", accepted, 1024);
      checkOutput("wrapLastAddr", lastRdAddr, 20'h001FF);
      checkOutput("wrapStatus", {oFound, oError, oSumOk, oSizeBlocks}, {3'b101, 8'h02});

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
